sifive_insight_instruction_tl_d_prot_echo_return: RTL and testbench
===================================================================

// Module: sifive_insight_instruction_tl_d_prot_echo_return
// PURPOSE
//  Responder-side companion to the instruction-fetch TL channel-A prot echo field.
//  Captures A-channel prot echo bits per source ID on each A fire, then returns them on D-channel beats.
//  Releases the slot after the last D beat and blocks A reuse of an in-flight source.
//  Sits between the fetch-unit TL master port and the Insight trace/fabric edge.
// PARAMETERS
//  SOURCE_W    2  A/D source ID width; table depth = 2**SOURCE_W
//  PROT_W      7  prot echo width {fetch,secure,privileged,writealloc,readalloc,modifiable,bufferable}
//  SIZE_W      3  log2 transfer-size field width
//  BEAT_BYTES  8  data bytes per D beat (power of 2)
// PORTS
//  clock         in   1         single clock, rising edge
//  reset         in   1         synchronous, active-high
//  a_valid_in    in   1         upstream A valid
//  a_ready_in    out  1         upstream A ready
//  a_source      in   SOURCE_W  A source ID
//  a_prot        in   PROT_W    A prot echo bits
//  a_valid_out   out  1         downstream A valid
//  a_ready_out   in   1         downstream A ready
//  d_valid_in    in   1         downstream D valid
//  d_ready_in    out  1         downstream D ready
//  d_opcode      in   3         D opcode (1 = AccessAckData)
//  d_size        in   SIZE_W    D log2 size
//  d_source_in   in   SOURCE_W  D source ID
//  d_valid_out   out  1         upstream D valid
//  d_ready_out   in   1         upstream D ready
//  d_source_out  out  SOURCE_W  registered D source
//  d_prot        out  PROT_W    returned prot echo
//  d_last        out  1         last beat of this response
//  orphan_err    out  1         sticky: D beat for source not in flight
// BEHAVIOUR
//  Reset: all inflight bits 0, beat counter 0, skid empty.
//   d_valid_out=0, orphan_err=0, d_prot/d_source_out/d_last=0. Table contents are don't-care.
//  A path is combinational (0 latency):
//   a_valid_out = a_valid_in & ~inflight[a_source]
//   a_ready_in  = a_ready_out & ~inflight[a_source]
//  A fire (a_valid_out & a_ready_out): table[a_source] <= a_prot; inflight[a_source] <= 1.
//  D beats: beats = (d_opcode==1) ? max(1, 2**d_size/BEAT_BYTES) : 1.
//   A beat counter counts accepted D beats. A beat is last when counter == beats-1; the counter then wraps to 0.
//  D path: 2-entry skid (register slice), 1-cycle latency, full throughput.
//   d_ready_in = ~skid_full. Output is held stable while d_valid_out & ~d_ready_out.
//  Each D beat accepted loads {d_source_in, table[d_source_in], last} into the slice.
//  On an accepted last beat: inflight[d_source_in] <= 0.
//   That source is re-acceptable on A the following cycle; no A/D bypass.
//  Same-cycle A fire and D last beat for different sources: both take effect.
//  Same-cycle A fire and D last beat for the same source cannot occur, because A is blocked while the source is in flight.
//  D beat with inflight[d_source_in]==0: orphan_err <= 1 (sticky until reset).
//   The beat still passes with d_prot = table value and inflight unchanged.
//  Reset mid-burst: the counter and inflight bits clear; partial responses are discarded.
// CONFIGURATION
//  SIFIVE_INSIGHT_PROT_ECHO_PARITY_EN
//   Defined: the table stores an even-parity bit per entry. On D load, a recomputed mismatch sets
//    output port parity_err (1 bit, sticky, reset 0).
//   Undefined: no parity storage and no parity_err port.
// STRUCTURE
//  Package sifive_insight_tl_echo_pkg holds:
//   tl_d_opcode_e (AccessAck=0, AccessAckData=1)
//   prot_echo_t (packed PROT_W struct)
//   function tl_num_beats(opcode, size, beat_bytes)
//  Sub-module sifive_insight_tl_skid_slice (parameterized payload width) implements the D register slice.
// TESTING
//  Single fetch: A src=1 prot=7'h41, D AccessAckData size=3 -> one beat, d_prot=7'h41, d_last=1, inflight[1] clears.
//  Burst: A src=2 prot=7'h05, D AccessAckData size=5 (BEAT_BYTES=8) -> 4 beats, all d_prot=7'h05, d_last only on beat 4.
//  Reuse block: A src=0 in flight, second A src=0 -> a_ready_in=0 until the cycle after the last D beat.
//  Backpressure: d_ready_out=0 for 5 cycles during a 4-beat burst -> no beat lost or duplicated, output stable, d_ready_in low only when skid full.
//  Orphan: D src=3 with nothing in flight -> orphan_err=1 the next cycle and stays 1; reset mid-burst -> all outputs 0, inflight cleared.
//  Parity (macro defined): force a table bit flip -> parity_err=1 on the next D return.

Source files
------------

// File: rtl/sifive_insight_tl_echo_pkg.sv
// rtl/sifive_insight_tl_echo_pkg.sv - shared TL D-channel types and beat-count helper for the prot echo return path
//
// Purpose: opcode enum, prot echo field layout, and the D-response beat count
//          helper used by sifive_insight_instruction_tl_d_prot_echo_return.
// Ports:   none (package).

package sifive_insight_tl_echo_pkg;

  typedef enum logic [2:0] {
    ACCESS_ACK      = 3'd0,
    ACCESS_ACK_DATA = 3'd1
  } tl_d_opcode_e;

  typedef struct packed {
    logic fetch;
    logic secure;
    logic privileged;
    logic writealloc;
    logic readalloc;
    logic modifiable;
    logic bufferable;
  } prot_echo_t;

  localparam int PROT_ECHO_W = $bits(prot_echo_t);

  // Data responses span 2**size bytes spread over beat_bytes-wide beats,
  // at least one beat; every other opcode is a single beat.
  function automatic int tl_num_beats(input logic [2:0] opcode, input int size,
                                      input int beat_bytes);
    int n;
    n = 1;
    if (opcode == ACCESS_ACK_DATA) begin
      n = (1 << size) / beat_bytes;
      if (n < 1) n = 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/sifive_insight_tl_skid_slice.sv
// rtl/sifive_insight_tl_skid_slice.sv - two-entry register slice, one-cycle latency, full throughput
//
// Purpose: registered output stage plus one skid entry so the upstream ready
//          depends only on local state.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   s_tvalid/s_tready     upstream handshake, s_tdata payload in
//   m_tvalid/m_tready     downstream handshake, m_tdata payload out (0 after reset)

module sifive_insight_tl_skid_slice #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         s_tvalid,
  output logic         s_tready,
  input  logic [W-1:0] s_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic [W-1:0] m_tdata
);

  logic         skid_valid_q;
  logic [W-1:0] skid_data_q;
  logic         s_fire;

  // The skid only fills while the output is stalled, so "skid occupied"
  // is exactly "both entries full".
  assign s_tready = ~skid_valid_q;
  assign s_fire   = s_tvalid & s_tready;

  always_ff @(posedge clock) begin
    if (reset) begin
      m_tvalid     <= 1'b0;
      m_tdata      <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else if (~m_tvalid | m_tready) begin
      if (skid_valid_q) begin
        m_tvalid     <= 1'b1;
        m_tdata      <= skid_data_q;
        skid_valid_q <= 1'b0;
      end else begin
        m_tvalid <= s_fire;
        if (s_fire) m_tdata <= s_tdata;
      end
    end else if (s_fire) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= s_tdata;
    end
  end

endmodule

// File: rtl/sifive_insight_instruction_tl_d_prot_echo_return.sv
// rtl/sifive_insight_instruction_tl_d_prot_echo_return.sv - per-source prot echo capture on A, return on D
//
// Purpose: records a_prot per source on each A fire, blocks A for sources still
//          in flight, and returns the recorded prot with every D beat through a
//          two-entry register slice. The slot frees after the last D beat.
// Optional: SIFIVE_INSIGHT_PROT_ECHO_PARITY_EN adds an even-parity bit per table
//           entry and the sticky parity_err output.
// Ports:
//   clock, reset                   rising-edge clock, synchronous active-high reset
//   a_valid_in/a_ready_in          upstream A handshake; a_source, a_prot
//   a_valid_out/a_ready_out        downstream A handshake (combinational pass)
//   d_valid_in/d_ready_in          downstream D handshake; d_opcode, d_size, d_source_in
//   d_valid_out/d_ready_out        upstream D handshake; d_source_out, d_prot, d_last
//   orphan_err                     sticky: D beat arrived for a source not in flight
//   parity_err                     sticky table parity error (parity build only)

module sifive_insight_instruction_tl_d_prot_echo_return
  import sifive_insight_tl_echo_pkg::*;
#(
  parameter int SOURCE_W   = 2,
  parameter int PROT_W     = PROT_ECHO_W,
  parameter int SIZE_W     = 3,
  parameter int BEAT_BYTES = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_valid_in,
  output logic                a_ready_in,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [PROT_W-1:0]   a_prot,
  output logic                a_valid_out,
  input  logic                a_ready_out,
  input  logic                d_valid_in,
  output logic                d_ready_in,
  input  logic [2:0]          d_opcode,
  input  logic [SIZE_W-1:0]   d_size,
  input  logic [SOURCE_W-1:0] d_source_in,
  output logic                d_valid_out,
  input  logic                d_ready_out,
  output logic [SOURCE_W-1:0] d_source_out,
  output logic [PROT_W-1:0]   d_prot,
  output logic                d_last,
  output logic                orphan_err
`ifdef SIFIVE_INSIGHT_PROT_ECHO_PARITY_EN
  ,
  output logic                parity_err
`endif
);

  localparam int DEPTH = 2 ** SOURCE_W;
  // Largest response is 2**(2**SIZE_W - 1) bytes, so 2**SIZE_W bits always hold beats-1.
  localparam int CNT_W = 2 ** SIZE_W;
  localparam int PAY_W = SOURCE_W + PROT_W + 1;

  logic [DEPTH-1:0]  inflight_q;
  logic [DEPTH-1:0]  inflight_d;
  logic [PROT_W-1:0] table_q [DEPTH];
  logic [CNT_W-1:0]  beat_cnt_q;
  logic [CNT_W-1:0]  beats_m1;
  logic              a_blocked;
  logic              a_fire;
  logic              d_fire;
  logic              d_is_last;
  logic [PAY_W-1:0]  d_payload;
  logic [PAY_W-1:0]  d_slice_out;

  assign a_blocked   = inflight_q[a_source];
  assign a_valid_out = a_valid_in & ~a_blocked;
  assign a_ready_in  = a_ready_out & ~a_blocked;
  assign a_fire      = a_valid_in & a_ready_out & ~a_blocked;

  assign d_fire    = d_valid_in & d_ready_in;
  assign beats_m1  = CNT_W'(tl_num_beats(d_opcode, int'(d_size), BEAT_BYTES) - 1);
  assign d_is_last = (beat_cnt_q == beats_m1);

  // Release before capture: a same-cycle A fire on another source is kept,
  // and a stray orphan last beat can never cancel a fresh A capture.
  always_comb begin
    inflight_d = inflight_q;
    if (d_fire && d_is_last) inflight_d[d_source_in] = 1'b0;
    if (a_fire) inflight_d[a_source] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_q <= '0;
      beat_cnt_q <= '0;
      orphan_err <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      if (d_fire) begin
        beat_cnt_q <= d_is_last ? '0 : beat_cnt_q + 1'b1;
        if (!inflight_q[d_source_in]) orphan_err <= 1'b1;
      end
    end
  end

  // Table contents are meaningless outside the in-flight window, so no reset.
  always_ff @(posedge clock) begin
    if (a_fire) table_q[a_source] <= a_prot;
  end

`ifdef SIFIVE_INSIGHT_PROT_ECHO_PARITY_EN
  logic par_q [DEPTH];

  always_ff @(posedge clock) begin
    if (a_fire) par_q[a_source] <= ^a_prot;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else if (d_fire && ((^table_q[d_source_in]) != par_q[d_source_in])) begin
      parity_err <= 1'b1;
    end
  end
`endif

  assign d_payload = {d_source_in, table_q[d_source_in], d_is_last};

  sifive_insight_tl_skid_slice #(
    .W(PAY_W)
  ) u_d_slice (
    .clock   (clock),
    .reset   (reset),
    .s_tvalid(d_valid_in),
    .s_tready(d_ready_in),
    .s_tdata (d_payload),
    .m_tvalid(d_valid_out),
    .m_tready(d_ready_out),
    .m_tdata (d_slice_out)
  );

  assign {d_source_out, d_prot, d_last} = d_slice_out;

endmodule

// File: tb/tb_sifive_insight_instruction_tl_d_prot_echo_return.sv
// tb/tb_sifive_insight_instruction_tl_d_prot_echo_return.sv - self-checking bench for the prot echo return block

module tb_sifive_insight_instruction_tl_d_prot_echo_return;

  logic       clock = 1'b0;
  logic       reset;
  logic       a_valid_in, a_ready_in, a_valid_out, a_ready_out;
  logic [1:0] a_source;
  logic [6:0] a_prot;
  logic       d_valid_in, d_ready_in, d_valid_out, d_ready_out;
  logic [2:0] d_opcode, d_size;
  logic [1:0] d_source_in, d_source_out;
  logic [6:0] d_prot;
  logic       d_last, orphan_err;
`ifdef SIFIVE_INSIGHT_PROT_ECHO_PARITY_EN
  logic       parity_err;
`endif

  sifive_insight_instruction_tl_d_prot_echo_return dut (
    .clock       (clock),
    .reset       (reset),
    .a_valid_in  (a_valid_in),
    .a_ready_in  (a_ready_in),
    .a_source    (a_source),
    .a_prot      (a_prot),
    .a_valid_out (a_valid_out),
    .a_ready_out (a_ready_out),
    .d_valid_in  (d_valid_in),
    .d_ready_in  (d_ready_in),
    .d_opcode    (d_opcode),
    .d_size      (d_size),
    .d_source_in (d_source_in),
    .d_valid_out (d_valid_out),
    .d_ready_out (d_ready_out),
    .d_source_out(d_source_out),
    .d_prot      (d_prot),
    .d_last      (d_last),
    .orphan_err  (orphan_err)
`ifdef SIFIVE_INSIGHT_PROT_ECHO_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  always #5 clock = ~clock;

  int         total = 0;
  int         bad = 0;
  // Reference model: returned beats still owed upstream, prot per source,
  // which sources hold a slot, and the beat index within the current response.
  logic [9:0] q[$];
  logic [6:0] m_table[4];
  bit   [3:0] m_inflight;
  bit         m_orphan;
  int         m_cnt;
  bit         a_fired, d_fired, noise;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_beats(input logic [2:0] op, input logic [2:0] size);
    int bytes;
    if (op != 3'd1) return 1;
    bytes = 1 << size;
    return (bytes < 8) ? 1 : bytes / 8;
  endfunction

  // Check every visible output against the model, then advance one clock.
  task automatic tick();
    bit exp_dv, exp_dr, af, df, last;
    int b;
    #1;
    exp_dr = (q.size() < 2);
    exp_dv = (q.size() != 0);
    chk("a_valid_out", 32'(a_valid_out), 32'(a_valid_in & ~m_inflight[a_source]));
    chk("a_ready_in", 32'(a_ready_in), 32'(a_ready_out & ~m_inflight[a_source]));
    chk("d_ready_in", 32'(d_ready_in), 32'(exp_dr));
    chk("d_valid_out", 32'(d_valid_out), 32'(exp_dv));
    if (exp_dv) chk("d_payload", 32'({d_source_out, d_prot, d_last}), 32'(q[0]));
    chk("orphan_err", 32'(orphan_err), 32'(m_orphan));
    af = a_valid_in & a_ready_out & ~m_inflight[a_source];
    df = d_valid_in & exp_dr;
    if (exp_dv && d_ready_out) void'(q.pop_front());
    if (df) begin
      b = ref_beats(d_opcode, d_size);
      last = (m_cnt + 1 == b);
      q.push_back({d_source_in, m_table[d_source_in], last});
      if (!m_inflight[d_source_in]) m_orphan = 1'b1;
      else if (last) m_inflight[d_source_in] = 1'b0;
      m_cnt = last ? 0 : m_cnt + 1;
    end
    if (af) begin
      m_table[a_source]    = a_prot;
      m_inflight[a_source] = 1'b1;
    end
    a_fired = af;
    d_fired = df;
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    a_valid_in  = 1'b0;
    d_valid_in  = 1'b0;
    a_ready_out = 1'b1;
    d_ready_out = 1'b1;
    reset       = 1'b1;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    chk("rst_d_valid_out", 32'(d_valid_out), 32'd0);
    chk("rst_orphan_err", 32'(orphan_err), 32'd0);
    chk("rst_d_prot", 32'(d_prot), 32'd0);
    chk("rst_d_source_out", 32'(d_source_out), 32'd0);
    chk("rst_d_last", 32'(d_last), 32'd0);
    chk("rst_a_ready_in", 32'(a_ready_in), 32'd1);
`ifdef SIFIVE_INSIGHT_PROT_ECHO_PARITY_EN
    chk("rst_parity_err", 32'(parity_err), 32'd0);
`endif
    q.delete();
    m_inflight = '0;
    m_orphan   = 1'b0;
    m_cnt      = 0;
    reset      = 1'b0;
  endtask

  task automatic do_a(input logic [1:0] src, input logic [6:0] prot);
    int cyc;
    cyc         = 0;
    a_source    = src;
    a_prot      = prot;
    a_valid_in  = 1'b1;
    a_ready_out = 1'b1;
    do begin
      tick();
      cyc++;
    end while (!a_fired && cyc < 50);
    a_valid_in = 1'b0;
    chk("a_fire", 32'(a_fired), 32'd1);
  endtask

  task automatic do_d(input logic [1:0] src, input logic [2:0] op, input logic [2:0] size,
                      input int stall, input bit rnd);
    int beats, sent, cyc;
    beats       = ref_beats(op, size);
    sent        = 0;
    cyc         = 0;
    d_source_in = src;
    d_opcode    = op;
    d_size      = size;
    while (sent < beats && cyc < 400) begin
      d_valid_in  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      d_ready_out = (cyc < stall) ? 1'b0 : (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
      if (noise) begin
        a_valid_in  = 1'($urandom_range(0, 1));
        a_source    = 2'($urandom_range(0, 3));
        a_prot      = 7'($urandom);
        a_ready_out = 1'($urandom_range(0, 1));
      end
      tick();
      if (d_fired) sent++;
      cyc++;
    end
    d_valid_in = 1'b0;
    chk("d_beats_sent", 32'(sent), 32'(beats));
  endtask

  task automatic drain();
    int cyc;
    cyc         = 0;
    a_valid_in  = 1'b0;
    d_valid_in  = 1'b0;
    d_ready_out = 1'b1;
    a_ready_out = 1'b1;
    while (q.size() != 0 && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [1:0] src;
    noise       = 1'b0;
    a_source    = '0;
    a_prot      = '0;
    d_opcode    = '0;
    d_size      = '0;
    d_source_in = '0;
    reset_dut();

    // Single fetch: one beat, prot returned, slot released.
    do_a(2'd1, 7'h41);
    do_d(2'd1, 3'd1, 3'd3, 0, 1'b0);
    chk("single_valid", 32'(d_valid_out), 32'd1);
    chk("single_prot", 32'(d_prot), 32'h41);
    chk("single_last", 32'(d_last), 32'd1);
    drain();
    a_source = 2'd1;
    #1;
    chk("single_release", 32'(a_ready_in), 32'd1);

    // Four-beat burst.
    do_a(2'd2, 7'h05);
    do_d(2'd2, 3'd1, 3'd5, 0, 1'b0);
    drain();

    // Reuse block: second A on src 0 waits until the cycle after the last D beat.
    do_a(2'd0, 7'h12);
    a_source   = 2'd0;
    a_prot     = 7'h33;
    a_valid_in = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("reuse_blocked", 32'(a_ready_in), 32'd0);
    do_d(2'd0, 3'd1, 3'd4, 0, 1'b0);
    tick();
    chk("reuse_reaccept", 32'(a_fired), 32'd1);
    a_valid_in = 1'b0;
    drain();
    do_d(2'd0, 3'd0, 3'd0, 0, 1'b0);
    drain();

    // Backpressure: upstream stalls 5 cycles during a 4-beat burst.
    do_a(2'd3, 7'h2a);
    do_d(2'd3, 3'd1, 3'd5, 5, 1'b0);
    drain();

    // Orphan: src 3 is no longer in flight.
    do_d(2'd3, 3'd0, 3'd0, 0, 1'b0);
    tick();
    chk("orphan_set", 32'(orphan_err), 32'd1);
    drain();
    for (int i = 0; i < 3; i++) tick();
    chk("orphan_sticky", 32'(orphan_err), 32'd1);

    // Reset mid-burst, then the counter restarts from beat 0.
    do_a(2'd2, 7'h05);
    d_source_in = 2'd2;
    d_opcode    = 3'd1;
    d_size      = 3'd5;
    d_valid_in  = 1'b1;
    tick();
    tick();
    reset_dut();
    a_source = 2'd2;
    #1;
    chk("post_reset_src_free", 32'(a_ready_in), 32'd1);
    do_a(2'd2, 7'h66);
    do_d(2'd2, 3'd1, 3'd5, 0, 1'b0);
    drain();

`ifdef SIFIVE_INSIGHT_PROT_ECHO_PARITY_EN
    chk("parity_clean", 32'(parity_err), 32'd0);
    do_a(2'd1, 7'h10);
    dut.table_q[1] = dut.table_q[1] ^ 7'h01;
    m_table[1]     = 7'h11;
    do_d(2'd1, 3'd0, 3'd0, 0, 1'b0);
    chk("parity_err", 32'(parity_err), 32'd1);
    drain();
    reset_dut();
`endif

    // Randomized traffic with stray A requests on any source.
    noise = 1'b1;
    for (int it = 0; it < 40; it++) begin
      src = 2'($urandom_range(0, 3));
      if (!m_inflight[src]) do_a(src, 7'($urandom));
      do_d(src, 3'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 0, 1'b1);
    end
    noise = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
